// File: rtl/sc_config_pkg.sv
// Shared scan-converter register map and config-loader FSM state type.
package sc_config_pkg;

  localparam logic [3:0] SC_STATUS       = 4'h0;
  localparam logic [3:0] SC_CONTROL      = 4'h1;
  localparam logic [3:0] SC_INT_CONFIG   = 4'h2;
  localparam logic [3:0] H_IN_CONFIG     = 4'h3;
  localparam logic [3:0] H_IN_CONFIG2    = 4'h4;
  localparam logic [3:0] V_IN_CONFIG     = 4'h5;
  localparam logic [3:0] V_IN_CONFIG2    = 4'h6;
  localparam logic [3:0] H_OUT_CONFIG    = 4'h7;
  localparam logic [3:0] H_OUT_CONFIG2   = 4'h8;
  localparam logic [3:0] V_OUT_CONFIG    = 4'h9;
  localparam logic [3:0] V_OUT_CONFIG2   = 4'ha;
  localparam logic [3:0] H_SCALE_CONFIG  = 4'hb;
  localparam logic [3:0] V_SCALE_CONFIG  = 4'hc;
  localparam logic [3:0] XY_OUT_CONFIG   = 4'hd;

  localparam int unsigned NUM_CFG_REGS = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } ld_state_t;

endpackage

// File: rtl/sc_config_loader.sv
// Avalon-MM master that writes every enabled config word to consecutive
// sc_config registers, then reads back the status word.
// Optional feature macro: SC_CONFIG_LOADER_TIMEOUT_EN (per-transfer wait
// limit that aborts the load and raises a sticky error_o).
module sc_config_loader
  import sc_config_pkg::*;
#(
  parameter int unsigned     NUM_REGS       = NUM_CFG_REGS,
  parameter int unsigned     ADDR_W         = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = H_IN_CONFIG,
  parameter logic [ADDR_W-1:0] STATUS_ADDR  = SC_STATUS,
  parameter int unsigned     TIMEOUT_CYCLES = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [32*NUM_REGS-1:0] cfg_words_i,
  input  logic [NUM_REGS-1:0]   cfg_mask_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic [31:0]           status_o,
  output logic [ADDR_W-1:0]     avalon_m_address,
  output logic [31:0]           avalon_m_writedata,
  output logic [3:0]            avalon_m_byteenable,
  output logic                  avalon_m_write,
  output logic                  avalon_m_read,
  output logic                  avalon_m_chipselect,
  input  logic [31:0]           avalon_m_readdata,
  input  logic                  avalon_m_waitrequest_n
);

  localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REGS - 1);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES - 1);

  // The counter logic is always written out; with the feature off TMO_EN
  // folds it away to a constant-zero register and error_o stays 0.
`ifdef SC_CONFIG_LOADER_TIMEOUT_EN
  localparam logic TMO_EN = 1'b1;
`else
  localparam logic TMO_EN = 1'b0;
`endif

  ld_state_t            state, state_nxt;
  logic [IDX_W-1:0]     idx, idx_nxt;
  logic [NUM_REGS-1:0]  mask, mask_nxt;
  logic [31:0]          status, status_nxt;
  logic                 err, err_nxt;
  logic [TMO_W-1:0]     tcnt, tcnt_nxt;

  logic wr_en, rd_en, req, stall, timeout;

  // State, index, latched mask, status capture and timeout counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= IDLE;
      idx    <= '0;
      mask   <= '0;
      status <= '0;
      err    <= 1'b0;
      tcnt   <= '0;
    end else begin
      state  <= state_nxt;
      idx    <= idx_nxt;
      mask   <= mask_nxt;
      status <= status_nxt;
      err    <= err_nxt;
      tcnt   <= tcnt_nxt;
    end
  end

  // Next-state logic and combinational bus decode of the registered state.
  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    mask_nxt   = mask;
    status_nxt = status;
    err_nxt    = err;

    wr_en   = (state == WRITE) && mask[idx];
    rd_en   = (state == READ);
    req     = wr_en || rd_en;
    stall   = req && !avalon_m_waitrequest_n;
    timeout = TMO_EN && stall && (tcnt == TMO_LIMIT);
    tcnt_nxt = (TMO_EN && stall && !timeout) ? tcnt + 1'b1 : '0;

    unique case (state)
      IDLE: begin
        if (start_i) begin
          mask_nxt  = cfg_mask_i;
          idx_nxt   = '0;
          err_nxt   = 1'b0;
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        if (timeout) begin
          err_nxt   = 1'b1;
          state_nxt = DONE;
        end else if (!mask[idx] || avalon_m_waitrequest_n) begin
          if (idx == LAST_IDX) begin
            state_nxt = READ;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      READ: begin
        if (timeout) begin
          err_nxt   = 1'b1;
          state_nxt = DONE;
        end else if (avalon_m_waitrequest_n) begin
          status_nxt = avalon_m_readdata;
          state_nxt  = DONE;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    avalon_m_write      = wr_en;
    avalon_m_read       = rd_en;
    avalon_m_chipselect = req;
    avalon_m_byteenable = req ? 4'hF : 4'h0;
    avalon_m_address    = '0;
    avalon_m_writedata  = '0;
    if (wr_en) begin
      avalon_m_address   = BASE_ADDR + ADDR_W'(idx);
      avalon_m_writedata = cfg_words_i[32*int'(idx) +: 32];
    end else if (rd_en) begin
      avalon_m_address = STATUS_ADDR;
    end
  end

  assign busy_o   = (state != IDLE);
  assign done_o   = (state == DONE);
  assign error_o  = err;
  assign status_o = status;

endmodule

// File: tb/tb_sc_config_loader.sv
// Self-checking bench for sc_config_loader: a transaction-level model builds
// the expected per-cycle bus trace, and every cycle is compared against it.
module tb_sc_config_loader;

  localparam int unsigned N     = 11;
  localparam int unsigned TMO   = 8;
  localparam logic [31:0] RDATA = 32'hDEADBEEF;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [32*N-1:0]   words;
  logic [N-1:0]      mask = '0;
  logic              busy, done, err;
  logic [31:0]       status;
  logic [3:0]        addr;
  logic [31:0]       wdata;
  logic [3:0]        be;
  logic              wr, rd, cs;
  logic [31:0]       rdata = RDATA;
  logic              wrn = 1'b1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        busy, done, wr, rd, err, wrn;
    logic [3:0]  addr;
    logic [31:0] data, status;
  } cyc_t;

  cyc_t        plan[$];
  logic [3:0]  wlog[$];
  logic [31:0] m_status = '0;
  logic        m_err = 1'b0;

  always #5 clk = ~clk;

  sc_config_loader #(
    .NUM_REGS(N),
    .ADDR_W(4),
    .BASE_ADDR(4'h3),
    .STATUS_ADDR(4'h0),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .start_i(start),
    .cfg_words_i(words),
    .cfg_mask_i(mask),
    .busy_o(busy),
    .done_o(done),
    .error_o(err),
    .status_o(status),
    .avalon_m_address(addr),
    .avalon_m_writedata(wdata),
    .avalon_m_byteenable(be),
    .avalon_m_write(wr),
    .avalon_m_read(rd),
    .avalon_m_chipselect(cs),
    .avalon_m_readdata(rdata),
    .avalon_m_waitrequest_n(wrn)
  );

  function automatic logic [31:0] word_val(input int k);
    return 32'hA000_0000 + 32'(k) * 32'h0101_0101;
  endfunction

  task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic cyc_t idle_c();
    cyc_t c;
    c.busy = 1'b0; c.done = 1'b0; c.wr = 1'b0; c.rd = 1'b0;
    c.err = m_err; c.wrn = 1'b1; c.addr = '0; c.data = '0; c.status = m_status;
    return c;
  endfunction

  // Expected trace: one entry per cycle starting with the cycle after start.
  // st_idx selects the stalled transfer (N = status read), st_n its wait cycles.
  task automatic build(input logic [N-1:0] msk, input int st_idx, input int st_n);
    cyc_t c;
    bit   aborted;
    bit   active;
    int   n;
    aborted = 1'b0;
    plan.delete();
    m_err = 1'b0;
    for (int k = 0; k <= int'(N); k++) begin
      if (aborted) break;
      n = (k == st_idx) ? st_n : 0;
      active = 1'b1;
      if (k < int'(N)) active = msk[k];
      c = idle_c();
      c.busy = 1'b1;
      if (!active) begin
        plan.push_back(c);
        continue;
      end
      if (k < int'(N)) begin
        c.wr = 1'b1; c.addr = 4'(3 + k); c.data = word_val(k);
      end else begin
        c.rd = 1'b1; c.addr = 4'h0;
      end
`ifdef SC_CONFIG_LOADER_TIMEOUT_EN
      if (n >= int'(TMO)) begin
        n = TMO;
        aborted = 1'b1;
      end
`endif
      c.wrn = 1'b0;
      repeat (n) plan.push_back(c);
      if (aborted) begin
        m_err = 1'b1;
      end else begin
        c.wrn = 1'b1;
        plan.push_back(c);
        if (k == int'(N)) m_status = RDATA;
      end
    end
    c = idle_c();
    c.busy = 1'b1;
    c.done = 1'b1;
    plan.push_back(c);
    for (int i = 0; i < 3; i++) plan.push_back(idle_c());
  endtask

  task automatic run(input logic [N-1:0] msk, input int st_idx, input int st_n,
                     input int restart_at, input int exp_done_cyc);
    int ndone;
    int done_cyc;
    cyc_t e;
    ndone = 0;
    done_cyc = -1;
    wlog.delete();
    build(msk, st_idx, st_n);
    @(negedge clk);
    mask  = msk;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mask  = '0;
    for (int i = 0; i < plan.size(); i++) begin
      e = plan[i];
      wrn   = e.wrn;
      start = (i + 1 == restart_at);
      #1;
      chk("busy",       i + 1, 32'(busy),  32'(e.busy));
      chk("done",       i + 1, 32'(done),  32'(e.done));
      chk("error",      i + 1, 32'(err),   32'(e.err));
      chk("write",      i + 1, 32'(wr),    32'(e.wr));
      chk("read",       i + 1, 32'(rd),    32'(e.rd));
      chk("chipselect", i + 1, 32'(cs),    32'(e.wr | e.rd));
      chk("byteenable", i + 1, 32'(be),    (e.wr | e.rd) ? 32'hF : 32'h0);
      chk("address",    i + 1, 32'(addr),  32'(e.addr));
      chk("writedata",  i + 1, wdata,      e.data);
      chk("status",     i + 1, status,     e.status);
      if (wr && wrn) wlog.push_back(addr);
      if (done) begin
        ndone++;
        if (done_cyc < 0) done_cyc = i + 1;
      end
      @(negedge clk);
    end
    start = 1'b0;
    wrn   = 1'b1;
    chk("done_cycle", 0, 32'(done_cyc), 32'(exp_done_cyc));
    chk("done_count", 0, 32'(ndone), 32'd1);
  endtask

  initial begin
    for (int k = 0; k < int'(N); k++) words[32*k +: 32] = word_val(k);

    // Reset state.
    #2;
    chk("rst_busy",   0, 32'(busy), 32'd0);
    chk("rst_done",   0, 32'(done), 32'd0);
    chk("rst_error",  0, 32'(err),  32'd0);
    chk("rst_status", 0, status,    32'd0);
    chk("rst_bus",    0, {22'd0, wr, rd, cs, be, 1'b0, addr != 4'h0}, 32'd0);
    chk("rst_wdata",  0, wdata,     32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Full mask, no wait states.
    run(11'h7FF, -1, 0, 0, 13);
    chk("full_status_lit", 0, status, 32'hDEADBEEF);
    chk("full_nwrites",    0, 32'(wlog.size()), 32'd11);
    if (wlog.size() == 11) begin
      chk("full_first_addr", 0, 32'(wlog[0]),  32'd3);
      chk("full_last_addr",  0, 32'(wlog[10]), 32'd13);
    end

    // Sparse mask: only words 0 and 2.
    run(11'b000_0000_0101, -1, 0, 0, 13);
    chk("sparse_nwrites", 0, 32'(wlog.size()), 32'd2);
    if (wlog.size() == 2) begin
      chk("sparse_addr0", 0, 32'(wlog[0]), 32'd3);
      chk("sparse_addr1", 0, 32'(wlog[1]), 32'd5);
    end

    // Three wait states on word 2.
    run(11'h7FF, 2, 3, 0, 16);

    // Second start during the load is ignored.
    run(11'h7FF, -1, 0, 5, 13);

    // All-zero mask still walks every slot before reading status.
    run(11'h000, -1, 0, 0, 13);
    chk("zero_nwrites", 0, 32'(wlog.size()), 32'd0);

    // Wait states on the status read.
    run(11'h7FF, int'(N), 2, 0, 15);

    // Reset in the middle of the write of word 4.
    @(negedge clk);
    mask  = 11'h7FF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("mid_write_addr", 5, 32'(addr), 32'd7);
    chk("mid_write_req",  5, 32'(wr),   32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_write",  5, 32'(wr),   32'd0);
    chk("rst_mid_cs",     5, 32'(cs),   32'd0);
    chk("rst_mid_busy",   5, 32'(busy), 32'd0);
    chk("rst_mid_addr",   5, 32'(addr), 32'd0);
    chk("rst_mid_status", 5, status,    32'd0);
    m_status = '0;
    @(negedge clk);
    rst = 1'b0;
    run(11'h7FF, -1, 0, 0, 13);
    if (wlog.size() > 0) chk("restart_first_addr", 0, 32'(wlog[0]), 32'd3);
    else chk("restart_nwrites", 0, 32'(wlog.size()), 32'd11);

`ifdef SC_CONFIG_LOADER_TIMEOUT_EN
    // Slave never accepts word 0: abort after TMO waits, DONE in cycle TMO+1.
    run(11'h7FF, 0, 1000, 0, 9);
    chk("tmo_error_sticky", 0, 32'(err), 32'd1);
    chk("tmo_status_kept",  0, status,   32'hDEADBEEF);
    run(11'h7FF, -1, 0, 0, 13);
    chk("tmo_error_cleared", 0, 32'(err), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog time=%0t got=timeout expected=finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sc_config_loader.md
# sc_config_loader

Avalon-MM master that pushes a complete scan-converter configuration set into the sc_config register slave without CPU involvement, then reads back the SC status word. It sits beside the Nios/CPU master on the same interconnect and is used for fast hardware-driven mode switches: one start pulse writes every enabled config word to consecutive register addresses, honouring waitrequest. On completion it returns the captured status.

## Interface
Parameters:
- NUM_REGS, 11, number of config words; word k goes to address BASE_ADDR+k
- BASE_ADDR, 4'h3, address of first config register (H_IN_CONFIG)
- STATUS_ADDR, 4'h0, address read after the write pass (SC_STATUS)
- ADDR_W, 4, Avalon address width
- TIMEOUT_CYCLES, 255, wait limit per transfer (used only with timeout feature)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-high
- start_i  in  1  single-cycle request to begin a load
- cfg_words_i  in  32*NUM_REGS  config words, word k at bits [32k+31:32k]; must be stable while busy_o=1
- cfg_mask_i  in  NUM_REGS  bit k=1: write word k; 0: skip
- busy_o  out  1  high from the cycle after an accepted start until the end of the DONE state
- done_o  out  1  one-cycle completion pulse
- error_o  out  1  sticky timeout flag; cleared by next accepted start
- status_o  out  32  status word captured in READ
- avalon_m_address  out  ADDR_W
- avalon_m_writedata  out  32
- avalon_m_byteenable  out  4  always 4'hF while a request is active, else 0
- avalon_m_write  out  1
- avalon_m_read  out  1
- avalon_m_chipselect  out  1  = write | read
- avalon_m_readdata  in  32
- avalon_m_waitrequest_n  in  1  active-low waitrequest; transfer accepted when request high and this high

## Operation
- Reset values: state IDLE, index 0, latched mask 0, busy_o/done_o/error_o 0, status_o 0, all bus outputs 0.
- IDLE: start_i=1 latches cfg_mask_i, clears index and error_o → WRITE. start_i while not IDLE is ignored.
- WRITE (index k): if mask[k]=1, drive write=1, address=BASE_ADDR+k, writedata=word k; hold until waitrequest_n=1, then k+1. If mask[k]=0, no bus activity, spend exactly one cycle, k+1. After k=NUM_REGS-1 completes → READ.
- READ: drive read=1, address=STATUS_ADDR; on waitrequest_n=1 capture avalon_m_readdata into status_o → DONE. Zero-latency read (data valid in the accept cycle).
- DONE: done_o=1 for one cycle → IDLE.
- Bus outputs are combinational decode of registered state/index; writedata muxes live cfg_words_i.
- Mask all-zero: still NUM_REGS skip cycles, then READ.
- Address arithmetic: BASE_ADDR+k computed in ADDR_W bits, wraps modulo 2^ADDR_W (no check).
- Reset mid-transfer: bus requests drop immediately (async); no partial state survives.

## Timing
- start_i sampled in cycle 0; with waitrequest_n permanently 1: WRITE cycles 1..NUM_REGS, READ at NUM_REGS+1, done_o at NUM_REGS+2 (13 for defaults).
- Each waitrequest_n=0 cycle on an active request adds exactly one cycle.
- busy_o high cycles 1..NUM_REGS+2 inclusive.
- status_o updates at the clock edge ending READ and holds until the next READ.

## Configuration
- SC_CONFIG_LOADER_TIMEOUT_EN defined: counter counts consecutive cycles with a request active and waitrequest_n=0, cleared on accept. Counter reaching TIMEOUT_CYCLES aborts: request dropped the next cycle, error_o=1, → DONE (done_o pulses), status_o unchanged.
- Not defined: no counter; master waits indefinitely; error_o tied 0.

## Structure
- Shared package sc_config_pkg: register-number localparams (SC_STATUS=0 … XY_OUT_CONFIG=4'hd), NUM_CFG_REGS=11, loader FSM state enum (IDLE, WRITE, READ, DONE).
- Single module; no sub-module needed (timeout counter inline).

## Test plan
- Default params, mask 11'h7FF, waitrequest_n=1: writes to addresses 3..13 with words 0..10 in consecutive cycles, read of address 0 returns 32'hDEADBEEF → status_o=32'hDEADBEEF, done_o at cycle 13.
- Mask 11'b000_0000_0101: writes only to addresses 3 and 5; done_o still at cycle 13.
- Slave holds waitrequest_n=0 for 3 cycles on word 2: write held stable with same address/data, done_o at cycle 16.
- start_i pulsed again at cycle 5: ignored; exactly one sequence and one done_o.
- rst_i asserted during WRITE of word 4: write/chipselect drop same cycle, all outputs 0, next start begins at word 0.
- With SC_CONFIG_LOADER_TIMEOUT_EN, TIMEOUT_CYCLES=8, waitrequest_n stuck 0: error_o=1, done_o pulses, status_o unchanged; next start clears error_o.
